// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU datapath, with a one-entry tagged response buffer.
// Define ALU_ARB_RR_EN for a round-robin tie-break; otherwise port 0 always wins ties.

module alu_arbiter_alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  input  logic [4:0]   shamt,
  output logic [W-1:0] c,
  output logic         zero
);
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_SLLV = 4'd12;

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    c = a;
    case (op)
      ALU_NOP:  c = a;
      ALU_ADD:  c = a + b;
      ALU_SUB:  c = a - b;
      ALU_AND:  c = a & b;
      ALU_OR:   c = a | b;
      ALU_SLT:  c = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: c = {{(W-1){1'b0}}, (a < b)};
      ALU_NOR:  c = ~(a | b);
      ALU_SLL:  c = b << shamt;
      ALU_SRL:  c = b >> shamt;
      ALU_SRA:  c = $unsigned($signed(b) >>> shamt);
      ALU_LUI:  c = b << 16;
      ALU_SLLV: c = b << a[4:0];
      default:  c = a;
    endcase
    zero = (c == '0);
  end
endmodule

module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req0_op,
  input  logic [3:0]   req1_op,
  input  logic [4:0]   req0_shamt,
  input  logic [4:0]   req1_shamt,
  output logic         rsp_valid,
  output logic         rsp_port,
  output logic [W-1:0] rsp_c,
  output logic         rsp_zero,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic         busy
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t     state, state_next;
  logic           drain, can_accept, any_valid, accept, grant;
  logic [W-1:0]   alu_a, alu_b, alu_c;
  logic [3:0]     alu_op;
  logic [4:0]     alu_shamt;
  logic           alu_zero;

`ifdef ALU_ARB_RR_EN
  logic last;
`endif

  assign rsp_valid  = (state == FULL);
  assign drain      = rsp_valid & (rsp_port ? rsp1_ready : rsp0_ready);
  assign can_accept = (state == EMPTY) | drain;
  assign any_valid  = req0_valid | req1_valid;
  // Readies are masked while reset is asserted so no handshake completes in the reset cycle.
  assign accept     = rstn & can_accept & any_valid;
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept &  grant;
  assign busy       = rsp_valid & ~drain;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant = ~last;
`else
      grant = 1'b0;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign alu_a     = grant ? req1_a     : req0_a;
  assign alu_b     = grant ? req1_b     : req0_b;
  assign alu_op    = grant ? req1_op    : req0_op;
  assign alu_shamt = grant ? req1_shamt : req0_shamt;

  alu_arbiter_alu #(.W(W)) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .op    (alu_op),
    .shamt (alu_shamt),
    .c     (alu_c),
    .zero  (alu_zero)
  );

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (!accept && drain) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= EMPTY;
    else       state <= state_next;
  end

  // NOTE: the payload registers are reset because their reset values are visible on the outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_port <= 1'b0;
      rsp_c    <= '0;
      rsp_zero <= 1'b0;
    end else if (accept) begin
      rsp_port <= grant;
      rsp_c    <= alu_c;
      rsp_zero <= alu_zero;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Pointer moves only on an accepted request; a drain alone leaves it alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       last <= 1'b1;
    else if (accept) last <= grant;
  end
`endif
endmodule
